// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction fetch with request/grant memory bus, in-order
//            response queue, PC hold and flush-driven discard of stale fetches.
// Revision : 1.0
// ============================================================================
module if_fetch_stage #(
  parameter int ADDR_W      = 32,
  parameter int INST_W      = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [ADDR_W-1:0] pc2if_addr_i,
  output logic              if2pc_hold_o,
  input  logic              cu2if_flush_i,
  output logic              if2mem_req_o,
  output logic [ADDR_W-1:0] if2mem_addr_o,
  input  logic              mem2if_gnt_i,
  input  logic              mem2if_rvalid_i,
  input  logic [INST_W-1:0] mem2if_rdata_i,
  input  logic              id2if_stall_i,
  output logic              if2id_valid_o,
  output logic [INST_W-1:0] if2id_inst_o,
  output logic [ADDR_W-1:0] if2id_pc_o
);

  localparam int c_PTR_W = $clog2(OUTSTANDING);
  localparam int c_CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic [c_CNT_W:0] c_LIMIT = (c_CNT_W + 1)'(OUTSTANDING);

  logic [c_CNT_W-1:0] r_inflight;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_discard;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_tag_wr_ptr;
  logic [c_PTR_W-1:0] r_tag_rd_ptr;
  logic [INST_W-1:0]  r_q_inst [OUTSTANDING];
  logic [ADDR_W-1:0]  r_q_pc   [OUTSTANDING];
  logic [ADDR_W-1:0]  r_tag    [OUTSTANDING];

  logic               w_pop;
  logic               w_issue;
  logic               w_rsp;
  logic               w_push;
  logic [c_CNT_W:0]   w_used;
  logic [c_CNT_W-1:0] w_inflight_nxt;

  // Credits count what will still be occupied after this cycle's pop.
  assign w_used = {1'b0, r_inflight} + {1'b0, r_count} - {{c_CNT_W{1'b0}}, w_pop};

  assign if2id_valid_o  = (r_count != '0) & ~cu2if_flush_i;
  assign if2id_inst_o   = r_q_inst[r_rd_ptr];
  assign if2id_pc_o     = r_q_pc[r_rd_ptr];
  assign w_pop          = if2id_valid_o & ~id2if_stall_i;

  assign if2mem_req_o   = rest & ~cu2if_flush_i & (w_used < c_LIMIT);
  assign if2mem_addr_o  = pc2if_addr_i;
  assign w_issue        = if2mem_req_o & mem2if_gnt_i;
  assign if2pc_hold_o   = ~w_issue & ~cu2if_flush_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign w_rsp          = mem2if_rvalid_i & (r_inflight != '0);
  assign w_push         = w_rsp & ~cu2if_flush_i & (r_discard == '0);
  assign w_inflight_nxt = r_inflight + c_CNT_W'(w_issue) - c_CNT_W'(w_rsp);

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_inflight   <= '0;
      r_count      <= '0;
      r_discard    <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tag_wr_ptr <= '0;
      r_tag_rd_ptr <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_issue) r_tag_wr_ptr <= r_tag_wr_ptr + 1'b1;
      if (w_rsp)   r_tag_rd_ptr <= r_tag_rd_ptr + 1'b1;
      if (cu2if_flush_i) begin
        // Everything still outstanding after this cycle is stale.
        r_count   <= '0;
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_discard <= w_inflight_nxt;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        if (w_rsp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      for (int i = 0; i < OUTSTANDING; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
        r_tag[i]    <= '0;
      end
    end else begin
      if (w_push) begin
        r_q_inst[r_wr_ptr] <= mem2if_rdata_i;
        r_q_pc[r_wr_ptr]   <= r_tag[r_tag_rd_ptr];
      end
      if (w_issue) r_tag[r_tag_wr_ptr] <= pc2if_addr_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Directed self-checking bench with PC and fixed-latency memory model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic        gnt = 1'b1;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        stall = 1'b0;
  logic        hold, req, valid_o;
  logic [31:0] addr_o, inst_o, pc_o;

  typedef struct {
    logic [31:0] a;
    int          due;
  } pend_t;

  pend_t       mem_q[$];
  int          cyc = 0;
  int          lat = 1;
  bit          mem_pause = 1'b0;
  logic [31:0] jump_tgt = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  if_fetch_stage #(.ADDR_W(32), .INST_W(32), .OUTSTANDING(2)) dut (
    .clk             (clk),
    .rest            (rest),
    .pc2if_addr_i    (pc),
    .if2pc_hold_o    (hold),
    .cu2if_flush_i   (flush),
    .if2mem_req_o    (req),
    .if2mem_addr_o   (addr_o),
    .mem2if_gnt_i    (gnt),
    .mem2if_rvalid_i (rvalid),
    .mem2if_rdata_i  (rdata),
    .id2if_stall_i   (stall),
    .if2id_valid_o   (valid_o),
    .if2id_inst_o    (inst_o),
    .if2id_pc_o      (pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic drive_mem();
    if (!mem_pause && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = inst_of(mem_q[0].a);
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
    end
  endtask

  // Called with outputs settled; advances one clock and updates PC/memory.
  task automatic tick();
    logic        g;
    logic        h;
    pend_t       p;
    g   = req & gnt;
    h   = hold;
    p.a = addr_o;
    p.due = cyc + lat;
    if (rvalid) void'(mem_q.pop_front());
    if (g) mem_q.push_back(p);
    @(posedge clk);
    #1;
    cyc++;
    if (flush)   pc = jump_tgt;
    else if (!h) pc = pc + 32'd4;
    flush = 1'b0;
    drive_mem();
  endtask

  task automatic do_reset();
    rest = 1'b0; flush = 1'b0; stall = 1'b0; gnt = 1'b1; mem_pause = 1'b0;
    mem_q.delete(); rvalid = 1'b0; rdata = '0; pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rest = 1'b1;
    drive_mem();
  endtask

  task automatic test_reset();
    #1 rest = 1'b0;
    #1;
    n_cmp++;
    if ({req, valid_o, inst_o, pc_o, hold} !== {1'b0, 1'b0, 32'h0, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: got req=%b v=%b inst=%h pc=%h hold=%b want 0 0 0 0 1",
               req, valid_o, inst_o, pc_o, hold);
    end
    @(posedge clk);
    #1 rest = 1'b1;
    #1;
    n_cmp++;
    if ({req, addr_o} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_first_req: got req=%b addr=%h want 1 00000000", req, addr_o);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    do_reset(); lat = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_cmp++;
      if (hold !== 1'b0) begin
        n_bad++; $display("FAIL stream_hold c%0d: got %b want 0", c, hold);
      end
      n_cmp++;
      if (c >= 2) begin
        ep = 32'(4 * (c - 2));
        if ({valid_o, pc_o, inst_o} !== {1'b1, ep, inst_of(ep)}) begin
          n_bad++;
          $display("FAIL stream_out c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                   c, valid_o, pc_o, inst_o, ep, inst_of(ep));
        end
      end else if (valid_o !== 1'b0) begin
        n_bad++; $display("FAIL stream_early c%0d: got v=%b want 0", c, valid_o);
      end
      tick();
    end
  endtask

  task automatic test_gnt_wait();
    logic [31:0] ep;
    do_reset(); lat = 1;
    for (int c = 0; c < 11; c++) begin
      gnt = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) begin
        n_cmp++;
        if ({req, addr_o, hold} !== {1'b1, 32'h10, 1'b1}) begin
          n_bad++;
          $display("FAIL gnt_wait c%0d: got req=%b addr=%h hold=%b want 1 00000010 1",
                   c, req, addr_o, hold);
        end
      end
      if (c == 7) begin
        n_cmp++;
        if (hold !== 1'b0) begin
          n_bad++; $display("FAIL gnt_accept c%0d: got hold=%b want 0", c, hold);
        end
      end
      n_cmp++;
      if ((c >= 2 && c <= 5) || c >= 9) begin
        ep = (c >= 9) ? 32'(16 + 4 * (c - 9)) : 32'(4 * (c - 2));
        if ({valid_o, pc_o, inst_o} !== {1'b1, ep, inst_of(ep)}) begin
          n_bad++;
          $display("FAIL gnt_out c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h",
                   c, valid_o, pc_o, inst_o, ep);
        end
      end else if (valid_o !== 1'b0) begin
        n_bad++; $display("FAIL gnt_gap c%0d: got v=%b want 0", c, valid_o);
      end
      tick();
    end
    gnt = 1'b1;
  endtask

  task automatic test_stall();
    logic [31:0] ep;
    do_reset(); lat = 1;
    for (int c = 0; c < 11; c++) begin
      stall = (c >= 2 && c <= 6);
      #1;
      if (c >= 2 && c <= 6) begin
        n_cmp++;
        if ({valid_o, pc_o, inst_o, req, hold} !== {1'b1, 32'h0, inst_of(32'h0), 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL stall_hold c%0d: got v=%b pc=%h inst=%h req=%b hold=%b want 1 0 %h 0 1",
                   c, valid_o, pc_o, inst_o, req, hold, inst_of(32'h0));
        end
      end else if (c >= 7) begin
        ep = 32'(4 * (c - 7));
        n_cmp++;
        if ({valid_o, pc_o, inst_o} !== {1'b1, ep, inst_of(ep)}) begin
          n_bad++;
          $display("FAIL stall_drain c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h",
                   c, valid_o, pc_o, inst_o, ep);
        end
      end
      tick();
    end
    stall = 1'b0;
  endtask

  task automatic test_flush();
    do_reset(); lat = 3; jump_tgt = 32'h100;
    for (int c = 0; c < 10; c++) begin
      flush = (c == 2);
      #1;
      if (c == 2) begin
        n_cmp++;
        if ({req, hold} !== {1'b0, 1'b0}) begin
          n_bad++; $display("FAIL flush_req c%0d: got req=%b hold=%b want 0 0", c, req, hold);
        end
      end
      if (c >= 2 && c <= 7) begin
        n_cmp++;
        if (valid_o !== 1'b0) begin
          n_bad++; $display("FAIL flush_stale c%0d: got v=%b pc=%h want v=0", c, valid_o, pc_o);
        end
      end else if (c >= 8) begin
        n_cmp++;
        if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h100 + 32'(4 * (c - 8)), inst_of(32'h100 + 32'(4 * (c - 8)))}) begin
          n_bad++;
          $display("FAIL flush_target c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h",
                   c, valid_o, pc_o, inst_o, 32'h100 + 32'(4 * (c - 8)));
        end
      end
      tick();
    end
  endtask

  task automatic test_flush_pop();
    do_reset(); lat = 1; jump_tgt = 32'h40;
    for (int c = 0; c < 7; c++) begin
      flush = (c == 2);
      #1;
      if (c == 2) begin
        n_cmp++;
        if ({valid_o, req, hold} !== {1'b0, 1'b0, 1'b0}) begin
          n_bad++;
          $display("FAIL flushpop_cycle: got v=%b req=%b hold=%b want 0 0 0", valid_o, req, hold);
        end
      end else if (c == 3 || c == 4) begin
        n_cmp++;
        if (valid_o !== 1'b0) begin
          n_bad++; $display("FAIL flushpop_drop c%0d: got v=%b pc=%h want v=0", c, valid_o, pc_o);
        end
      end else if (c >= 5) begin
        n_cmp++;
        if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h40 + 32'(4 * (c - 5)), inst_of(32'h40 + 32'(4 * (c - 5)))}) begin
          n_bad++;
          $display("FAIL flushpop_target c%0d: got v=%b pc=%h inst=%h want v=1 pc=%h",
                   c, valid_o, pc_o, inst_o, 32'h40 + 32'(4 * (c - 5)));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); lat = 3;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c == 3) mem_pause = 1'b1;
      tick();
    end
    // One response buffered, one still in flight at the memory.
    stall = 1'b1;
    #1;
    n_cmp++;
    if ({valid_o, pc_o, inst_o, req} !== {1'b1, 32'h0, inst_of(32'h0), 1'b0}) begin
      n_bad++;
      $display("FAIL midrst_pre: got v=%b pc=%h inst=%h req=%b want 1 0 %h 0",
               valid_o, pc_o, inst_o, req, inst_of(32'h0));
    end
    #2 rest = 1'b0;
    #1;
    n_cmp++;
    if ({req, valid_o, inst_o, pc_o} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL midrst_async: got req=%b v=%b inst=%h pc=%h want 0 0 0 0",
               req, valid_o, inst_o, pc_o);
    end
    mem_pause = 1'b0; stall = 1'b0; gnt = 1'b0; pc = '0;
    @(posedge clk);
    #1;
    cyc++;
    rest = 1'b1;
    drive_mem();
    for (int r = 0; r < 7; r++) begin
      gnt = (r >= 2);
      #1;
      if (r == 0) begin
        n_cmp++;
        if ({req, addr_o} !== {1'b1, 32'h0}) begin
          n_bad++; $display("FAIL midrst_resume: got req=%b addr=%h want 1 00000000", req, addr_o);
        end
      end
      n_cmp++;
      if (r < 6) begin
        if (valid_o !== 1'b0) begin
          n_bad++; $display("FAIL midrst_late r%0d: got v=%b pc=%h want v=0", r, valid_o, pc_o);
        end
      end else if ({valid_o, pc_o, inst_o} !== {1'b1, 32'h0, inst_of(32'h0)}) begin
        n_bad++;
        $display("FAIL midrst_first: got v=%b pc=%h inst=%h want v=1 pc=0 inst=%h",
                 valid_o, pc_o, inst_o, inst_of(32'h0));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gnt_wait();
    test_stall();
    test_flush();
    test_flush_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
